mips_regfile: RTL and testbench

//   32 x 32-bit general-purpose register file for the single-cycle MIPS datapath.

---
 rtl/mips_pkg.sv | 16 +
 rtl/regfile_read_port.sv | 52 +++++
 rtl/mips_regfile.sv | 88 ++++++++
 tb/tb_mips_regfile.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
//   Architectural constants shared by the register file, the control block and
//   the write-destination mux of the single-cycle MIPS datapath.
//   No ports.
// -----------------------------------------------------------------------------
package mips_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 2 ** REG_ADDR_W;
    localparam int DATA_W     = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;   // hardwired zero
    localparam logic [REG_ADDR_W-1:0] REG_RA   = 5'd31;  // jal link target

endpackage : mips_pkg

// File: rtl/regfile_read_port.sv
// -----------------------------------------------------------------------------
// regfile_read_port
//   One combinational read port of the register file: NUM_REGS:1 mux, forced
//   zero for register 0, and optional same-cycle write forwarding.
// Ports
//   regs     in   NUM_REGS x DATA_W  flattened register contents
//   rd_addr  in   ADDR_W             read index
//   we       in   1                  write enable of the write port
//   wr_addr  in   ADDR_W             write index of the write port
//   wr_data  in   DATA_W             write data of the write port
//   rd_data  out  DATA_W             read data
// -----------------------------------------------------------------------------
module regfile_read_port #(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int ADDR_W = mips_pkg::REG_ADDR_W,
    parameter int BYPASS = 0
) (
    input  logic [(2**ADDR_W)-1:0][DATA_W-1:0] regs,
    input  logic [ADDR_W-1:0]                  rd_addr,
    input  logic                               we,
    input  logic [ADDR_W-1:0]                  wr_addr,
    input  logic [DATA_W-1:0]                  wr_data,
    output logic [DATA_W-1:0]                  rd_data
);
    import mips_pkg::*;

    logic w_hit;

    generate
        if (BYPASS != 0) begin : g_bypass
            assign w_hit = we && (wr_addr == rd_addr);
        end else begin : g_no_bypass
            // Write-port inputs are only needed for forwarding.
            logic w_unused_bypass;
            assign w_unused_bypass = &{1'b0, we, wr_addr, wr_data};
            assign w_hit = 1'b0;
        end
    endgenerate

    // NOTE: every branch of a combinational block must assign its outputs;
    // the default first line keeps this a mux and not a latch.
    always_comb begin
        rd_data = regs[rd_addr];
        if (rd_addr == ADDR_W'(REG_ZERO)) begin
            // r0 masks everything, including a forwarded write.
            rd_data = '0;
        end else if (w_hit) begin
            rd_data = wr_data;
        end
    end

endmodule : regfile_read_port

// File: rtl/mips_regfile.sv
// -----------------------------------------------------------------------------
// mips_regfile
//   32 x 32-bit general-purpose register file for the single-cycle MIPS core.
//   Two combinational read ports (rs, rt), one clocked write port, and a
//   debug read port that never forwards. Register 0 always reads zero.
// Ports
//   clk       in   1       rising-edge clock
//   rst       in   1       synchronous active-high reset, wins over we
//   rs_addr   in   ADDR_W  read port A index
//   rt_addr   in   ADDR_W  read port B index
//   rs_data   out  DATA_W  read port A data
//   rt_data   out  DATA_W  read port B data
//   we        in   1       write enable
//   wr_addr   in   ADDR_W  write index
//   wr_data   in   DATA_W  write data
//   dbg_addr  in   ADDR_W  debug read index
//   dbg_data  out  DATA_W  debug read data
// -----------------------------------------------------------------------------
module mips_regfile #(
    parameter int DATA_W      = mips_pkg::DATA_W,
    parameter int ADDR_W      = mips_pkg::REG_ADDR_W,
    parameter int BYPASS      = 0,   // keep 0 in the single-cycle core (comb loop)
    parameter int RESET_CLEAR = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);
    import mips_pkg::*;

    localparam int NREGS = 2 ** ADDR_W;

    logic [NREGS-1:0][DATA_W-1:0] r_regs;

    // NOTE: state uses non-blocking assignments so every register samples
    // values from before the edge, regardless of statement order.
    // NOTE: the whole array is resettable here because the reset is a real
    // architectural clear; a plain RAM would normally have no reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (RESET_CLEAR != 0) begin
                r_regs <= '0;
            end else begin
                r_regs[0] <= '0;
            end
        end else if (we && (wr_addr != ADDR_W'(REG_ZERO))) begin
            // we is tested first so an undriven wr_addr with we=0 is harmless.
            r_regs[wr_addr] <= wr_data;
        end
    end

    regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_rs_port (
        .regs    (r_regs),
        .rd_addr (rs_addr),
        .we      (we),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_data (rs_data)
    );

    regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_rt_port (
        .regs    (r_regs),
        .rd_addr (rt_addr),
        .we      (we),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_data (rt_data)
    );

    // Debug view shows committed state only.
    regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(0)) u_dbg_port (
        .regs    (r_regs),
        .rd_addr (dbg_addr),
        .we      (1'b0),
        .wr_addr ('0),
        .wr_data ('0),
        .rd_data (dbg_data)
    );

endmodule : mips_regfile

// File: tb/tb_mips_regfile.sv
// -----------------------------------------------------------------------------
// tb_mips_regfile
//   Drives a default build and a BYPASS=1 build of mips_regfile from the same
//   inputs. Expected read values come from an array model of the register
//   file and are queued per cycle; a negedge monitor drains the queue and
//   compares against the live outputs.
// -----------------------------------------------------------------------------
module tb_mips_regfile;

    typedef enum int {P_RS, P_RT, P_DBG, P_BRS, P_BRT} port_e;

    typedef struct {
        port_e       port;
        logic [31:0] exp;
        string       tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs_addr, rt_addr, wr_addr, dbg_addr;
    logic        we;
    logic [31:0] wr_data;
    logic [31:0] rs_data, rt_data, dbg_data;
    logic [31:0] b_rs_data, b_rt_data, b_dbg_data;

    logic [31:0] model [32];
    exp_t        sb [$];
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    mips_regfile dut (
        .clk      (clk),
        .rst      (rst),
        .rs_addr  (rs_addr),
        .rt_addr  (rt_addr),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .we       (we),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    mips_regfile #(.BYPASS(1)) dut_byp (
        .clk      (clk),
        .rst      (rst),
        .rs_addr  (rs_addr),
        .rt_addr  (rt_addr),
        .rs_data  (b_rs_data),
        .rt_data  (b_rt_data),
        .we       (we),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .dbg_addr (dbg_addr),
        .dbg_data (b_dbg_data)
    );

    // Reference reads: register 0 is zero, otherwise the committed value;
    // the forwarding build substitutes the in-flight write data on a match.
    function automatic logic [31:0] ref_read(input logic [4:0] a, input bit fwd);
        if (a == 5'd0) return 32'h0;
        if (fwd && we && (wr_addr == a)) return wr_data;
        return model[a];
    endfunction

    // One clock cycle: apply inputs, queue expectations for this cycle's
    // outputs, then commit the write/reset to the model at the edge.
    task automatic cycle(input bit r, input bit w, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [4:0] ra,
                         input logic [4:0] rb, input logic [4:0] da,
                         input bit chk, input string tag);
        rst = r; we = w; wr_addr = wa; wr_data = wd;
        rs_addr = ra; rt_addr = rb; dbg_addr = da;
        if (chk) begin
            sb.push_back('{P_RS,  ref_read(ra, 1'b0), tag});
            sb.push_back('{P_RT,  ref_read(rb, 1'b0), tag});
            sb.push_back('{P_DBG, ref_read(da, 1'b0), tag});
            sb.push_back('{P_BRS, ref_read(ra, 1'b1), tag});
            sb.push_back('{P_BRT, ref_read(rb, 1'b1), tag});
        end
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (w && wa != 5'd0) begin
            model[wa] = wd;
        end
        #1;
    endtask

    // Monitor: drains everything queued for the current cycle.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t        it;
            logic [31:0] act;
            it = sb.pop_front();
            case (it.port)
                P_RS:    act = rs_data;
                P_RT:    act = rt_data;
                P_DBG:   act = dbg_data;
                P_BRS:   act = b_rs_data;
                default: act = b_rt_data;
            endcase
            n_vec++;
            if (act !== it.exp) begin
                n_err++;
                $display("FAIL %s port=%s actual=%h required=%h",
                         it.tag, it.port.name(), act, it.exp);
            end
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        rst = 1'b0; we = 1'b0; wr_addr = '0; wr_data = '0;
        rs_addr = '0; rt_addr = '0; dbg_addr = '0;
        @(posedge clk); #1;

        // Reset, then every register reads zero on the debug port.
        cycle(1, 0, 0, 0, 0, 0, 0, 0, "reset");
        for (int i = 0; i < 32; i++)
            cycle(0, 0, 0, 0, 5'(i), 5'(31 - i), 5'(i), 1, "reset_sweep");

        // Write r8: old value before the edge, new value after.
        cycle(0, 1, 8, 32'hDEADBEEF, 8, 0, 8, 1, "r8_before_edge");
        cycle(0, 0, 0, 0, 8, 8, 8, 1, "r8_after_edge");

        // Write to r0 is discarded; forwarding must not leak it either.
        cycle(0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 1, "r0_write");
        cycle(0, 0, 0, 0, 0, 0, 0, 1, "r0_after");

        // Two ports, distinct and identical addresses.
        cycle(0, 1, 5, 32'h1, 0, 0, 5, 1, "w_r5");
        cycle(0, 1, 31, 32'h0040_0008, 5, 31, 31, 1, "w_r31");
        cycle(0, 0, 0, 0, 5, 31, 5, 1, "rs5_rt31");
        cycle(0, 0, 0, 0, 31, 31, 31, 1, "rs_eq_rt_31");

        // Reset beats a simultaneous write.
        cycle(0, 1, 9, 32'hA5A5A5A5, 9, 9, 9, 1, "w_r9");
        cycle(0, 0, 0, 0, 9, 9, 9, 1, "r9_set");
        cycle(1, 1, 9, 32'h1, 9, 5, 9, 0, "rst_vs_write");
        cycle(0, 0, 0, 0, 9, 5, 31, 1, "r9_after_rst");

        // Forwarding build: same-cycle bypass on a match, never for r0.
        cycle(0, 1, 12, 32'h77, 12, 12, 12, 1, "bypass_r12");
        cycle(0, 1, 0, 32'h77, 0, 0, 0, 1, "bypass_r0");
        cycle(0, 0, 0, 0, 12, 3, 12, 1, "r12_committed");

        // Undriven write index with we=0 must leave state untouched.
        cycle(0, 0, 5'bx, 32'hFFFF_0000, 12, 31, 5, 1, "x_wr_addr");
        for (int i = 0; i < 32; i++)
            cycle(0, 0, 0, 0, 5'(i), 12, 5'(i), 1, "x_sweep");

        // Randomized traffic with occasional resets and r0 writes.
        for (int n = 0; n < 400; n++) begin
            bit          r, w;
            logic [4:0]  wa, ra, rb, da;
            r  = ($urandom_range(0, 59) == 0);
            w  = ($urandom_range(0, 99) < 60);
            wa = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom);
            ra = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : 5'($urandom);
            da = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
            cycle(r, w, wa, $urandom, ra, rb, da, 1, "random");
        end

        // Give the monitor a bounded chance to drain the queue.
        repeat (2) @(negedge clk);
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_mips_regfile
